// File: rtl/uart_blk_pkg.sv
// Shared types and constants for the block-assembling UART receiver.
package uart_blk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned OSR       = 16;
    localparam logic [3:0]  MID_TICK  = 4'd7;
    localparam logic [3:0]  LAST_TICK = 4'd15;

endpackage

// File: rtl/uart_blk_tick.sv
// Oversample tick generator: one-cycle tick every baud_divisor+1 clocks.
module uart_blk_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud_divisor,
    output logic        tick
);

    logic [15:0] div_cnt;

    // >= rather than == so a divisor lowered mid-count wraps immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt >= baud_divisor) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_blk_rx.sv
// UART receiver (8N1, 16x oversample) that assembles BLK_BYTES bytes into a block.
// Optional inter-byte timeout flush enabled by defining UART_BLK_RX_TIMEOUT_EN.
module uart_blk_rx
    import uart_blk_pkg::*;
#(
    parameter int unsigned BLK_BYTES = 16,
    parameter int unsigned TMO_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            baud_divisor,
    input  logic                   rx,
    output logic [8*BLK_BYTES-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   frm_err,
    output logic                   ovr_err,
    output logic                   tmo_evt,
    output logic [1:0]             state
);

    localparam int unsigned IDX_W = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);

    logic                   rx_s1, rx_s2;
    logic                   tick;
    rx_state_t              st;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic [IDX_W-1:0]       byte_idx;
    logic [8*BLK_BYTES-1:0] blk_buf;
    logic                   blk_done;

`ifdef UART_BLK_RX_TIMEOUT_EN
    localparam int unsigned TMO_TICKS = TMO_BITS * OSR;
    localparam int unsigned TMO_W     = $clog2(TMO_TICKS + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign tmo_evt = 1'b0;
`endif

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    uart_blk_tick u_tick (
        .clk          (clk),
        .rst          (rst),
        .baud_divisor (baud_divisor),
        .tick         (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            blk_buf  <= '0;
            blk_done <= 1'b0;
            frm_err  <= 1'b0;
`ifdef UART_BLK_RX_TIMEOUT_EN
            tmo_cnt  <= '0;
            tmo_evt  <= 1'b0;
`endif
        end else begin
            blk_done <= 1'b0;
            frm_err  <= 1'b0;
`ifdef UART_BLK_RX_TIMEOUT_EN
            tmo_evt  <= 1'b0;
`endif
            if (tick) begin
                unique case (st)
                    ST_IDLE: begin
                        if (!rx_s2) begin
                            st       <= ST_START;
                            tick_cnt <= '0;
`ifdef UART_BLK_RX_TIMEOUT_EN
                            tmo_cnt  <= '0;
                        end else if (byte_idx != '0) begin
                            if (tmo_cnt == TMO_W'(TMO_TICKS - 1)) begin
                                tmo_cnt  <= '0;
                                byte_idx <= '0;
                                tmo_evt  <= 1'b1;
                            end else begin
                                tmo_cnt <= tmo_cnt + TMO_W'(1);
                            end
`endif
                        end
                    end
                    ST_START: begin
                        if (tick_cnt == MID_TICK) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            st       <= rx_s2 ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s2, shreg[7:1]};
                            if (bit_idx == 3'd7) begin
                                st <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            st       <= ST_IDLE;
                            if (rx_s2) begin
                                blk_buf[8*byte_idx +: 8] <= shreg;
                                if (byte_idx == LAST_IDX) begin
                                    byte_idx <= '0;
                                    blk_done <= 1'b1;
                                end else begin
                                    byte_idx <= byte_idx + IDX_W'(1);
                                end
                            end else begin
                                frm_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Completion beats a stalled consumer only when it is accepting this very cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_data  <= '0;
            blk_valid <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            ovr_err <= 1'b0;
            if (blk_done) begin
                if (!blk_valid || blk_ready) begin
                    blk_data  <= blk_buf;
                    blk_valid <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end else if (blk_valid && blk_ready) begin
                blk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_blk_rx.sv
// Directed bench for uart_blk_rx; timeout checks follow UART_BLK_RX_TIMEOUT_EN.
module tb_uart_blk_rx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx = 1'b1;
    logic         blk_ready = 1'b1;
    logic [15:0]  baud_divisor = 16'd0;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         frm_err;
    logic         ovr_err;
    logic         tmo_evt;
    logic [1:0]   state;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned  frm_cnt = 0;
    int unsigned  ovr_cnt = 0;
    int unsigned  tmo_cnt = 0;
    int unsigned  hs_cnt  = 0;
    logic [127:0] last_blk = '0;

    uart_blk_rx #(
        .BLK_BYTES (16),
        .TMO_BITS  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_divisor (baud_divisor),
        .rx           (rx),
        .blk_data     (blk_data),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .frm_err      (frm_err),
        .ovr_err      (ovr_err),
        .tmo_evt      (tmo_evt),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_err) frm_cnt++;
        if (ovr_err) ovr_cnt++;
        if (tmo_evt) tmo_cnt++;
        if (blk_valid && blk_ready) begin
            hs_cnt++;
            last_blk = blk_data;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b);
        hold_rx(1'b0, 16);
        for (int i = 0; i < 8; i++) hold_rx(d[i], 16);
        hold_rx(stop_b, 16);
        hold_rx(1'b1, 16);
    endtask

    task automatic send_seq(input logic [7:0] first, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_byte(first + 8'(i), 1'b1);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 blk_ready = v;
    endtask

    function automatic logic [127:0] seq_blk(input logic [7:0] first);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = first + 8'(k);
        return r;
    endfunction

    initial begin
        int unsigned f0, o0, t0, h0;

        repeat (4) @(negedge clk);
        check("rst_state", state, 2'd0);
        check("rst_valid", blk_valid, 1'b0);
        check("rst_data", blk_data, '0);
        check("rst_pulses", {frm_err, ovr_err, tmo_evt}, 3'b000);
        rst = 1'b0;
        hold_rx(1'b1, 20);

        // 16 frames 0x00..0x0F with consumer ready
        f0 = frm_cnt; o0 = ovr_cnt; h0 = hs_cnt;
        send_seq(8'h00, 16);
        hold_rx(1'b1, 20);
        check("blk0_count", hs_cnt - h0, 1);
        check("blk0_data", last_blk, 128'h0F0E0D0C0B0A09080706050403020100);
        check("blk0_valid_clr", blk_valid, 1'b0);
        check("blk0_no_err", (frm_cnt - f0) + (ovr_cnt - o0), 0);

        // 5-clock low glitch must be rejected without disturbing alignment
        f0 = frm_cnt; h0 = hs_cnt;
        hold_rx(1'b0, 5);
        hold_rx(1'b1, 30);
        check("glitch_state", state, 2'd0);
        check("glitch_no_frm", frm_cnt - f0, 0);
        send_seq(8'h10, 16);
        hold_rx(1'b1, 20);
        check("glitch_blk_count", hs_cnt - h0, 1);
        check("glitch_blk_data", last_blk, seq_blk(8'h10));

        // bad stop bit, then a clean block
        f0 = frm_cnt; h0 = hs_cnt;
        send_byte(8'hA5, 1'b0);
        hold_rx(1'b1, 16);
        check("frm_pulse", frm_cnt - f0, 1);
        send_seq(8'h20, 16);
        hold_rx(1'b1, 20);
        check("frm_blk_count", hs_cnt - h0, 1);
        check("frm_blk_data", last_blk, seq_blk(8'h20));
        check("frm_single", frm_cnt - f0, 1);

        // overrun: two blocks while consumer stalled
        set_ready(1'b0);
        o0 = ovr_cnt; h0 = hs_cnt;
        send_seq(8'h30, 16);
        send_seq(8'h40, 16);
        hold_rx(1'b1, 20);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_valid_held", blk_valid, 1'b1);
        check("ovr_data_held", blk_data, seq_blk(8'h30));
        check("ovr_no_hs", hs_cnt - h0, 0);
        set_ready(1'b1);
        hold_rx(1'b1, 4);
        check("ovr_hs_count", hs_cnt - h0, 1);
        check("ovr_hs_data", last_blk, seq_blk(8'h30));
        check("ovr_valid_clr", blk_valid, 1'b0);

        // 3 bytes, long idle, 16 bytes
        t0 = tmo_cnt; h0 = hs_cnt;
        send_seq(8'h50, 3);
        hold_rx(1'b1, 33 * 16);
        send_seq(8'h60, 16);
        hold_rx(1'b1, 20);
        check("tmo_blk_count", hs_cnt - h0, 1);
`ifdef UART_BLK_RX_TIMEOUT_EN
        check("tmo_pulse", tmo_cnt - t0, 1);
        check("tmo_blk_data", last_blk, seq_blk(8'h60));
`else
        check("tmo_none", tmo_cnt - t0, 0);
        check("tmo_partial_kept", last_blk, 128'h6C6B6A69686766656463626160525150);
`endif

        // reset during data bit 4 of the eighth byte
        send_seq(8'h70, 7);
        hold_rx(1'b0, 16);
        hold_rx(1'b1, 16);
        hold_rx(1'b1, 16);
        hold_rx(1'b1, 16);
        hold_rx(1'b0, 16);
        hold_rx(1'b1, 8);
        rst = 1'b1;
        hold_rx(1'b1, 3);
        check("rstmid_state", state, 2'd0);
        check("rstmid_valid", blk_valid, 1'b0);
        check("rstmid_data", blk_data, '0);
        rst = 1'b0;
        hold_rx(1'b1, 32);
        h0 = hs_cnt;
        send_seq(8'h80, 16);
        hold_rx(1'b1, 20);
        check("rstmid_blk_count", hs_cnt - h0, 1);
        check("rstmid_blk_data", last_blk, seq_blk(8'h80));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_blk_rx.md
UART_BLK_RX -- requirements
Module: uart_blk_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter BLK_BYTES, default 16, SHALL set the number of bytes per block.
REQ-003 Parameter TMO_BITS, default 32, SHALL set the inter-byte timeout in bit-times.
REQ-004 Port clk, input, 1, SHALL be the system clock.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port baud_divisor, input, 16, SHALL set the oversample tick period to baud_divisor+1 clocks.
REQ-007 Port rx, input, 1, SHALL be the asynchronous serial line, idle high.
REQ-008 Port blk_data, output, 8*BLK_BYTES, SHALL be the assembled block, with byte k in bits [8k+7:8k].
REQ-009 Port blk_valid, output, 1, SHALL indicate that blk_data holds an unconsumed block.
REQ-010 Port blk_ready, input, 1, SHALL be the consumer acceptance signal.
REQ-011 Port frm_err, output, 1, SHALL pulse for one cycle on a framing error.
REQ-012 Port ovr_err, output, 1, SHALL pulse for one cycle when a completed block is dropped.
REQ-013 Port tmo_evt, output, 1, SHALL pulse for one cycle when a partial block is flushed.
REQ-014 Port state, output, 2, SHALL carry the current byte-FSM state encoding.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer, and only the synchronized value SHALL be used.
REQ-016 The tick generator SHALL count 0..baud_divisor and emit a one-cycle tick on wrap; it SHALL give a tick every clock when baud_divisor=0.
REQ-017 Each serial bit SHALL span 16 ticks, and the frame SHALL be 1 start bit, 8 data bits LSB first, and 1 stop bit.
REQ-018 The FSM SHALL have states IDLE(0), START(1), DATA(2) and STOP(3), and SHALL advance only on ticks.
REQ-019 In IDLE, synchronized rx=0 on a tick SHALL clear the tick count and move the FSM to START.
REQ-020 In START, at tick count 7: rx=0 SHALL move to DATA with counters cleared; rx=1 SHALL return to IDLE with nothing recorded (glitch).
REQ-021 In DATA, each bit SHALL be sampled at tick count 15, i.e. mid-bit; after bit 7 the FSM SHALL go to STOP.
REQ-022 In STOP, at tick count 15: rx=1 SHALL write the byte into slot byte_idx and increment byte_idx; rx=0 SHALL discard the byte, pulse frm_err and leave byte_idx unchanged; either way the FSM SHALL return to IDLE.
REQ-023 When byte_idx reaches BLK_BYTES with blk_valid=0, blk_data SHALL load and blk_valid SHALL rise on the clock after the stop sample; byte_idx SHALL wrap to 0.
REQ-024 When a block completes while blk_valid=1 and blk_ready=0, the new block SHALL be dropped, ovr_err SHALL pulse, blk_data SHALL hold its value, and byte_idx SHALL wrap to 0.
REQ-025 The handshake SHALL complete on blk_valid&&blk_ready, clearing blk_valid next cycle.
REQ-026 If completion and handshake occur in the same cycle, the new block SHALL load and blk_valid SHALL stay 1 with no ovr_err.
REQ-027 Reception SHALL continue regardless of blk_ready, because the serial line cannot be stalled.

Reset
REQ-028 Reset SHALL set state=IDLE, all counters to 0, blk_data=0, blk_valid=0 and all pulses to 0; synchronizer flops SHALL reset to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame and the partial block; reception SHALL restart on the next start edge after release.

Configuration
REQ-030 With UART_BLK_RX_TIMEOUT_EN defined, IDLE time of TMO_BITS*16 ticks with byte_idx>0 SHALL clear byte_idx and pulse tmo_evt; the idle counter SHALL clear on each start detection.
REQ-031 With UART_BLK_RX_TIMEOUT_EN undefined, a partial block SHALL persist indefinitely, tmo_evt SHALL be tied to 0, and no timeout counter SHALL exist.

Structure
REQ-032 Package uart_blk_pkg SHALL hold the FSM state enum, OSR=16, MID_TICK=7 and LAST_TICK=15.
REQ-033 Tick generation SHALL be the sub-module uart_blk_tick (clk, rst, baud_divisor -> tick).

Verification
REQ-034 With divisor=0, 16 frames of bytes 0x00..0x0F and blk_ready=1: blk_valid SHALL pulse once with blk_data=128'h0F0E..0100.
REQ-035 A 5-clock low glitch on rx with divisor=0: there SHALL be no byte, no error, and state SHALL return to 0.
REQ-036 Byte 0xA5 with stop=0: frm_err SHALL pulse once, and the following 16 good bytes SHALL form the block unaffected.
REQ-037 Two full blocks with blk_ready=0: the first block SHALL be held, ovr_err SHALL pulse once, and after ready the first block's data SHALL be seen.
REQ-038 With TIMEOUT_EN, 3 bytes then 33 bit-times idle then 16 bytes: tmo_evt SHALL pulse, and the block SHALL equal the last 16 bytes.
REQ-039 Reset asserted at data bit 4 of byte 7, then 16 fresh bytes: the block SHALL contain only the fresh bytes.
